// File: rtl/des_pkg.sv
// des_pkg: shared DES tables, round primitives and FSM state type.
// Tables use 1-based MSB-first DES numbering: entry t selects source bit
// (W - t) of a W-bit vector. Permutation outputs are built MSB first.
package des_pkg;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ROUND = 2'd1, ST_DONE = 2'd2} state_t;

   localparam int IP_T [64] = '{
      58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
      57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   localparam int IPI_T [64] = '{
      40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
      36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
   localparam int E_T [48] = '{
      32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
      16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
   localparam int P_T [32] = '{
      16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
   localparam int PC1_T [56] = '{
      57,49,41,33,25,17,9,1, 58,50,42,34,26,18,10,2, 59,51,43,35,27,19,11,3, 60,52,44,36,
      63,55,47,39,31,23,15,7, 62,54,46,38,30,22,14,6, 61,53,45,37,29,21,13,5, 28,20,12,4};
   localparam int PC2_T [48] = '{
      14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
      41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

   // Right-rotate amount for decryption round i (index i-1): undoes the
   // left shift of encryption round 18-i; round 1 needs none since the
   // total encryption rotation is a full 28 bits.
   localparam int SHIFT_REV [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   // S-boxes, flat index = {row(b1,b6), col(b2..b5)}.
   localparam int SBOX [8][64] = '{
      '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
      '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
      '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
      '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
      '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
      '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
      '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
      '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

   function automatic logic [63:0] des_ip(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y = {y[62:0], 1'(x >> (64 - IP_T[6'(i)]))};
      return y;
   endfunction

   function automatic logic [63:0] des_ip_inv(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y = {y[62:0], 1'(x >> (64 - IPI_T[6'(i)]))};
      return y;
   endfunction

   function automatic logic [55:0] des_pc1(input logic [63:0] x);
      logic [55:0] y;
      y = '0;
      for (int i = 0; i < 56; i++) y = {y[54:0], 1'(x >> (64 - PC1_T[6'(i)]))};
      return y;
   endfunction

   function automatic logic [47:0] des_pc2(input logic [55:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y = {y[46:0], 1'(x >> (56 - PC2_T[6'(i)]))};
      return y;
   endfunction

   function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [47:0] ex;
      logic [31:0] s;
      logic [31:0] y;
      logic [5:0]  b;
      ex = '0;
      for (int i = 0; i < 48; i++) ex = {ex[46:0], 1'(r >> (32 - E_T[6'(i)]))};
      x = ex ^ k;
      s = '0;
      for (int j = 0; j < 8; j++) begin
         b = 6'(x >> (42 - 6 * j));
         s = {s[27:0], 4'(SBOX[3'(j)][{b[5], b[0], b[4:1]}])};
      end
      y = '0;
      for (int i = 0; i < 32; i++) y = {y[30:0], 1'(s >> (32 - P_T[5'(i)]))};
      return y;
   endfunction

endpackage

// File: rtl/des_ks_rev_step.sv
// des_ks_rev_step: one step of the reverse DES key schedule.
// Rotates C and D (28 bits each) right by the amount for round i_rnd and
// applies PC2 to the rotated value.
//   i_cd      : current {C,D}
//   i_rnd     : round number 1..16 (other values rotate by 0)
//   o_cd_next : rotated {C,D}
//   o_subkey  : PC2 of o_cd_next, i.e. encryption subkey K(17-i_rnd)
module des_ks_rev_step (
   input  logic [55:0] i_cd,
   input  logic [4:0]  i_rnd,
   output logic [55:0] o_cd_next,
   output logic [47:0] o_subkey
);
   import des_pkg::*;

   logic [1:0]  w_amt;
   logic [27:0] w_c, w_d;

   always_comb begin
      w_amt = 2'd0;
      if (i_rnd >= 5'd1 && i_rnd <= 5'd16) w_amt = 2'(SHIFT_REV[4'(i_rnd - 5'd1)]);
      case (w_amt)
         2'd1:    begin w_c = {i_cd[28], i_cd[55:29]};    w_d = {i_cd[0], i_cd[27:1]};   end
         2'd2:    begin w_c = {i_cd[29:28], i_cd[55:30]}; w_d = {i_cd[1:0], i_cd[27:2]}; end
         default: begin w_c = i_cd[55:28];                w_d = i_cd[27:0];              end
      endcase
   end

   assign o_cd_next = {w_c, w_d};
   assign o_subkey  = des_pc2(o_cd_next);

endmodule

// File: rtl/des_decrypt_iter.sv
// des_decrypt_iter: iterative DES decryption, one Feistel round per clock.
// Accepts ciphertext+key on in_valid/in_ready (only in IDLE), runs 16
// rounds, holds plaintext on out_valid until out_ready.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : input handshake; in_data ciphertext, in_key key
//   out_valid/out_ready : output handshake; out_data plaintext
//   key_par_err         : key had an even-parity byte (DES_DEC_PARITY_EN),
//                         otherwise constant 0
// Optional feature macro: DES_DEC_PARITY_EN.
module des_decrypt_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   input  logic [63:0] in_key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        key_par_err
);
   import des_pkg::*;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_l, r_r;
   logic [55:0] r_cd;
   logic [4:0]  r_rnd;
   logic [55:0] w_cd_nxt;
   logic [47:0] w_subkey;
   logic        w_accept;
   logic        w_rnd_ok;

   des_ks_rev_step u_ks (
      .i_cd      (r_cd),
      .i_rnd     (r_rnd),
      .o_cd_next (w_cd_nxt),
      .o_subkey  (w_subkey)
   );

   assign w_accept = in_valid && (r_state == ST_IDLE);
   assign w_rnd_ok = (r_rnd >= 5'd1) && (r_rnd <= 5'd16);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = ST_ROUND;
         end
         ST_ROUND: begin
            // A corrupted round counter abandons the block.
            if (!w_rnd_ok)             w_state_nxt = ST_IDLE;
            else if (r_rnd == 5'd16)   w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_l   <= '0;
         r_r   <= '0;
         r_cd  <= '0;
         r_rnd <= '0;
      end else if (w_accept) begin
         {r_l, r_r} <= des_ip(in_data);
         r_cd       <= des_pc1(in_key);
         r_rnd      <= 5'd1;
      end else if (r_state == ST_ROUND && w_rnd_ok) begin
         r_l   <= r_r;
         r_r   <= r_l ^ des_f(r_r, w_subkey);
         r_cd  <= w_cd_nxt;
         r_rnd <= r_rnd + 5'd1;
      end
   end

   // L/R only move in ROUND, so this is stable throughout DONE and is
   // IP_inv(0) = 0 out of reset. Halves swap as in the final DES round.
   assign out_data = des_ip_inv({r_r, r_l});

`ifdef DES_DEC_PARITY_EN
   logic r_key_par_err;
   logic w_par_bad;

   always_comb begin
      logic [7:0] v_byte;
      w_par_bad = 1'b0;
      v_byte    = '0;
      for (int k = 0; k < 8; k++) begin
         v_byte = 8'(in_key >> (8 * k));
         if (!(^v_byte)) w_par_bad = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_key_par_err <= 1'b0;
      else if (w_accept) r_key_par_err <= w_par_bad;
   end

   assign key_par_err = r_key_par_err;
`else
   assign key_par_err = 1'b0;
`endif

endmodule

// File: doc/des_decrypt_iter.md
# des_decrypt_iter

Iterative DES decryption core: accepts one 64-bit ciphertext block and 64-bit key via valid/ready, runs the 16 Feistel rounds one per clock using a reverse (right-rotating) key schedule, and presents the 64-bit plaintext via valid/ready. It is the receive-side counterpart of the combinational DES encryption path and shares the same permutation, S-box and round-function primitives. Bit numbering is 1-based MSB-first throughout: bit 64 is the first DES bit.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ciphertext/key offered
- in_ready  out  1  core can accept; high only in IDLE
- in_data  in  64  ciphertext block
- in_key  in  64  DES key, parity bits included
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer accepts plaintext
- out_data  out  64  plaintext block
- key_par_err  out  1  key parity error for the current result (only with DES_DEC_PARITY_EN; otherwise tied 0)

## Operation
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load {L,R} <= IP(in_data), CD <= PC1(in_key), rnd <= 1, go to ROUND.
- ROUND, round i = rnd (1..16):
  - CDe = CD rotated right per half (C and D independently, 28 bits each) by amt(i).
  - amt = 0 for i=1; 1 for i in {2,9,16}; 2 otherwise.
  - Subkey = PC2(CDe), which equals encryption subkey K(17-i).
  - Update: L <= R, R <= L ^ f(R, subkey), CD <= CDe, rnd <= rnd+1.
  - After round 16, go to DONE.
- DONE:
  - out_valid=1.
  - out_data = IP_inv({R,L}), with the halves swapped as in encryption.
  - On out_ready, go to IDLE.
- rnd is a 5-bit counter. Values 0 and 17..31 are unreachable; if reached, the core returns to IDLE.
- in_data and in_key are sampled only on the accept edge. Changes afterwards have no effect.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, key_par_err=0, state IDLE, L/R/CD/rnd cleared.
- Accept at edge N. Rounds complete at edges N+1..N+16. out_valid is high from edge N+16.
- Minimum latency is 16 cycles from accept to out_valid.
- Output handshake completes at edge M. out_valid=0 and in_ready=1 after edge M.
- Minimum period is 17 cycles per block. No overlap: in_ready=0 throughout ROUND and DONE.
- out_data and key_par_err are held stable while out_valid=1 && out_ready=0, for any number of stall cycles.
- out_ready while not out_valid is ignored. in_valid outside IDLE is ignored; the source must hold it.
- Reset asserted mid-ROUND or in DONE aborts immediately. All outputs take reset values and the in-flight block is discarded.

## Configuration
- DES_DEC_PARITY_EN defined:
  - At accept, each key byte in_key[8k:8k-7] is checked for odd parity.
  - Any even-parity byte sets a key_par_err register, which is cleared on the next accept.
  - Decryption still proceeds, since parity bits are ignored by PC1.
  - key_par_err is meaningful while out_valid=1.
- DES_DEC_PARITY_EN undefined: no checker logic; key_par_err is constant 0.

## Structure
- Shared package des_pkg holds:
  - IP, IP_inv, E, P, PC1 and PC2 index tables.
  - S-box tables.
  - The per-round shift schedule as a 16-entry constant.
  - The state enum.
- The round function reuses the existing f, and the permutations reuse the existing IP/IP_inv/PC1/PC2 modules.
- One new sub-module, des_ks_rev_step: combinational right-rotate of C and D by amt(rnd), plus PC2, producing the subkey and next CD.

## Test plan
- Reset, then in_data=0x8CA64DE9C1B123A7, key=0 -> out_data=0x0000000000000000 with out_valid exactly 16 cycles after accept; key_par_err=1 if DES_DEC_PARITY_EN.
- in_data=0x85E813540F0AB405, key=0x133457799BBCDFF1 -> out_data=0x0123456789ABCDEF, key_par_err=0.
- key=0x0101010101010101, in_data=0x8CA64DE9C1B123A7 -> 0x0000000000000000 (parity bits ignored), key_par_err=0.
- Hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0 throughout; release -> in_ready=1 next cycle; a second block accepted back-to-back decrypts correctly.
- Assert rst at round 8, then submit the vector from scenario 2 -> outputs reset immediately, then the correct plaintext with no stale state.
- Change in_data/in_key every cycle during ROUND -> result matches the values sampled at accept.
